// File: rtl/fma16_vector_runner.sv
// Self-check sequencer around the combinational fma16: fetch packed vectors, drive operands,
// compare result, count errors. Define FMA16_FLAGCHECK_EN to also check flags and add flag_errors.
module fma16_vector_runner #(
    parameter int unsigned ADDR_W = 14,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   num_vectors,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [75:0]       mem_data,
    output logic [15:0]       x,
    output logic [15:0]       y,
    output logic [15:0]       z,
    output logic              mul,
    output logic              add,
    output logic              negp,
    output logic              negz,
    output logic [1:0]        roundmode,
    input  logic [15:0]       result,
    input  logic [3:0]        flags,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  vectornum,
    output logic [CNT_W-1:0]  errors,
    output logic              mismatch,
    output logic [ADDR_W-1:0] first_err_idx,
    output logic              first_err_valid
`ifdef FMA16_FLAGCHECK_EN
    ,
    output logic [CNT_W-1:0]  flag_errors
`endif
);

    typedef enum logic [2:0] {StIdle, StFetch, StApply, StCheck, StDone} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [ADDR_W:0]   num_q, num_d;
    logic [15:0]       x_q, x_d, y_q, y_d, z_q, z_d, rexp_q, rexp_d;
    logic [5:0]        ctrl_q, ctrl_d;
    logic [CNT_W-1:0]  vectornum_q, vectornum_d, errors_q, errors_d;
    logic [ADDR_W-1:0] first_err_idx_q, first_err_idx_d;
    logic              first_err_valid_q, first_err_valid_d;
    logic              res_fail, vec_fail, last_vec;
    logic [CNT_W-1:0]  vectornum_inc;

    assign res_fail      = (result !== rexp_q);
    assign vectornum_inc = vectornum_q + CNT_W'(1);
    assign last_vec      = (vectornum_inc == CNT_W'(num_q));

`ifdef FMA16_FLAGCHECK_EN
    logic [3:0]       flagsexp_q, flagsexp_d;
    logic [CNT_W-1:0] flag_errors_q, flag_errors_d;
    logic             flag_fail;
    logic [1:0]       unused_ctrl;

    assign flag_fail   = (flags !== flagsexp_q);
    assign vec_fail    = res_fail | flag_fail;
    assign flag_errors = flag_errors_q;
    assign unused_ctrl = mem_data[27:26];
`else
    logic unused_bits;

    assign vec_fail    = res_fail;
    assign unused_bits = ^{flags, mem_data[27:26], mem_data[3:0]};
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q           <= StIdle;
            mem_addr_q        <= '0;
            num_q             <= '0;
            x_q               <= '0;
            y_q               <= '0;
            z_q               <= '0;
            rexp_q            <= '0;
            ctrl_q            <= '0;
            vectornum_q       <= '0;
            errors_q          <= '0;
            first_err_idx_q   <= '0;
            first_err_valid_q <= 1'b0;
`ifdef FMA16_FLAGCHECK_EN
            flagsexp_q        <= '0;
            flag_errors_q     <= '0;
`endif
        end else begin
            state_q           <= state_d;
            mem_addr_q        <= mem_addr_d;
            num_q             <= num_d;
            x_q               <= x_d;
            y_q               <= y_d;
            z_q               <= z_d;
            rexp_q            <= rexp_d;
            ctrl_q            <= ctrl_d;
            vectornum_q       <= vectornum_d;
            errors_q          <= errors_d;
            first_err_idx_q   <= first_err_idx_d;
            first_err_valid_q <= first_err_valid_d;
`ifdef FMA16_FLAGCHECK_EN
            flagsexp_q        <= flagsexp_d;
            flag_errors_q     <= flag_errors_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StDone: if (start) state_d = (num_vectors == '0) ? StDone : StFetch;
            StFetch:        state_d = StApply;
            StApply:        state_d = StCheck;
            StCheck:        state_d = last_vec ? StDone : StFetch;
            default:        state_d = StIdle;
        endcase
    end

    always_comb begin
        mem_addr_d        = mem_addr_q;
        num_d             = num_q;
        x_d               = x_q;
        y_d               = y_q;
        z_d               = z_q;
        rexp_d            = rexp_q;
        ctrl_d            = ctrl_q;
        vectornum_d       = vectornum_q;
        errors_d          = errors_q;
        first_err_idx_d   = first_err_idx_q;
        first_err_valid_d = first_err_valid_q;
`ifdef FMA16_FLAGCHECK_EN
        flagsexp_d        = flagsexp_q;
        flag_errors_d     = flag_errors_q;
`endif
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    num_d             = num_vectors;
                    mem_addr_d        = '0;
                    vectornum_d       = '0;
                    errors_d          = '0;
                    first_err_valid_d = 1'b0;
`ifdef FMA16_FLAGCHECK_EN
                    flag_errors_d     = '0;
`endif
                end
            end
            StApply: begin
                x_d    = mem_data[75:60];
                y_d    = mem_data[59:44];
                z_d    = mem_data[43:28];
                ctrl_d = mem_data[25:20];
                rexp_d = mem_data[19:4];
`ifdef FMA16_FLAGCHECK_EN
                flagsexp_d = mem_data[3:0];
`endif
            end
            StCheck: begin
                vectornum_d = vectornum_inc;
                // Hold the address after the final vector so a full-depth run never wraps early.
                if (!last_vec) mem_addr_d = vectornum_inc[ADDR_W-1:0];
                if (vec_fail) begin
                    if (errors_q != {CNT_W{1'b1}}) errors_d = errors_q + CNT_W'(1);
                    if (!first_err_valid_q) begin
                        first_err_idx_d   = vectornum_q[ADDR_W-1:0];
                        first_err_valid_d = 1'b1;
                    end
                end
`ifdef FMA16_FLAGCHECK_EN
                if (flag_fail && flag_errors_q != {CNT_W{1'b1}}) begin
                    flag_errors_d = flag_errors_q + CNT_W'(1);
                end
`endif
            end
            default: ;
        endcase
    end

    always_comb begin
        mem_rd   = (state_q == StFetch);
        busy     = (state_q == StFetch) || (state_q == StApply) || (state_q == StCheck);
        done     = (state_q == StDone);
        mismatch = (state_q == StCheck) && vec_fail;
    end

    assign mem_addr        = mem_addr_q;
    assign x               = x_q;
    assign y               = y_q;
    assign z               = z_q;
    assign roundmode       = ctrl_q[5:4];
    assign mul             = ctrl_q[3];
    assign add             = ctrl_q[2];
    assign negp            = ctrl_q[1];
    assign negz            = ctrl_q[0];
    assign vectornum       = vectornum_q;
    assign errors          = errors_q;
    assign first_err_idx   = first_err_idx_q;
    assign first_err_valid = first_err_valid_q;

endmodule

// File: tb/tb_fma16_vector_runner.sv
// Directed bench for fma16_vector_runner with a synchronous vector memory and a toy fma16
// (x==3C00 returns y, else x^y^z). Honours FMA16_FLAGCHECK_EN like the design.
module tb_fma16_vector_runner;

    localparam int unsigned ADDR_W = 14;
    localparam int unsigned CNT_W  = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W:0]   num_vectors;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [75:0]       mem_data = '0;
    logic [15:0]       x, y, z, result;
    logic              mul, add, negp, negz;
    logic [1:0]        roundmode;
    logic [3:0]        flags, flags_drv;
    logic              busy, done, mismatch, first_err_valid;
    logic [CNT_W-1:0]  vectornum, errors;
    logic [ADDR_W-1:0] first_err_idx;
`ifdef FMA16_FLAGCHECK_EN
    logic [CNT_W-1:0]  flag_errors;
`endif

    logic [75:0] vmem [0:(1<<ADDR_W)-1];
    int n_checks = 0;
    int n_fail   = 0;
    int mm_count = 0;
    int rd_count = 0;
    int mm_idx   = -1;
    int cyc;
    int base_mm, base_rd;

    always #5 clk = ~clk;

    fma16_vector_runner #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .start(start), .num_vectors(num_vectors),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data),
        .x(x), .y(y), .z(z), .mul(mul), .add(add), .negp(negp), .negz(negz),
        .roundmode(roundmode), .result(result), .flags(flags),
        .busy(busy), .done(done), .vectornum(vectornum), .errors(errors),
        .mismatch(mismatch), .first_err_idx(first_err_idx), .first_err_valid(first_err_valid)
`ifdef FMA16_FLAGCHECK_EN
        , .flag_errors(flag_errors)
`endif
    );

    always @(posedge clk) if (mem_rd) mem_data <= vmem[mem_addr];

    assign result = (x == 16'h3C00) ? y : (x ^ y ^ z);
    assign flags  = flags_drv;

    always @(negedge clk) begin
        if (mismatch) begin
            mm_count <= mm_count + 1;
            mm_idx   <= int'(vectornum);
        end
        if (mem_rd) rd_count <= rd_count + 1;
    end

    function automatic logic [75:0] pk(input logic [15:0] vx, input logic [15:0] vy,
                                       input logic [15:0] vz, input logic [7:0] ctrl,
                                       input logic [15:0] rexp, input logic [3:0] fexp);
        return {vx, vy, vz, ctrl, rexp, fexp};
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of the first cycle after start.
    task automatic pulse_start(input int n);
        start       = 1'b1;
        num_vectors = n[ADDR_W:0];
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int from_cyc, output int c);
        c = from_cyc;
        while (done !== 1'b1 && c < 200) begin
            @(negedge clk);
            c++;
        end
        check_eq("done_reached", done, 1'b1);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; num_vectors = '0; flags_drv = 4'h0;
        vmem[0] = pk(16'h3C00, 16'h4000, 16'h0000, 8'h08, 16'h4000, 4'h0);
        repeat (2) @(negedge clk);
        check_eq("rst_x", x, 0);
        check_eq("rst_vnum", vectornum, 0);
        check_eq("rst_flags_out", {mem_rd, busy, done, first_err_valid, mul}, 0);
        reset = 1'b1;
        @(negedge clk);

        // Single vector
        base_mm = mm_count;
        pulse_start(1);
        check_eq("t1_rd_c1", mem_rd, 1'b1);
        check_eq("t1_addr_c1", mem_addr, 0);
        check_eq("t1_busy", busy, 1'b1);
        @(negedge clk);
        check_eq("t1_rd_c2", mem_rd, 1'b0);
        check_eq("t1_x_c2", x, 16'h0000);
        @(negedge clk);
        check_eq("t1_xyz_c3", {x, y, z}, {16'h3C00, 16'h4000, 16'h0000});
        check_eq("t1_ctrl_c3", {roundmode, mul, add, negp, negz}, 6'b00_1000);
        wait_done(3, cyc);
        check_eq("t1_latency", cyc, 4);
        check_eq("t1_vnum", vectornum, 1);
        check_eq("t1_errors", errors, 0);
        check_eq("t1_mismatch", mm_count - base_mm, 0);
        check_eq("t1_busy_done", busy, 1'b0);

        // Four vectors, index 2 expects 4200 but the datapath returns 4000
        vmem[0] = pk(16'h3C00, 16'h4000, 16'h0000, 8'h08, 16'h4000, 4'h0);
        vmem[1] = pk(16'h3C00, 16'h4400, 16'h0000, 8'h3C, 16'h4400, 4'h0);
        vmem[2] = pk(16'h3C00, 16'h4000, 16'h0000, 8'h05, 16'h4200, 4'h0);
        vmem[3] = pk(16'h3C00, 16'h3800, 16'h0000, 8'h12, 16'h3800, 4'h0);
        base_mm = mm_count; base_rd = rd_count;
        pulse_start(4);
        wait_done(1, cyc);
        check_eq("t2_latency", cyc, 13);
        check_eq("t2_errors", errors, 1);
        check_eq("t2_mm_pulses", mm_count - base_mm, 1);
        check_eq("t2_mm_idx", mm_idx, 2);
        check_eq("t2_first_idx", first_err_idx, 2);
        check_eq("t2_first_valid", first_err_valid, 1'b1);
        check_eq("t2_vnum", vectornum, 4);
        check_eq("t2_reads", rd_count - base_rd, 4);
        check_eq("t2_hold_y", y, 16'h3800);
        check_eq("t2_hold_ctrl", {roundmode, mul, add, negp, negz}, 6'b01_0010);

        // Zero-length run
        base_rd = rd_count;
        pulse_start(0);
        check_eq("t3_done", done, 1'b1);
        check_eq("t3_rd", mem_rd, 1'b0);
        check_eq("t3_errors", errors, 0);
        check_eq("t3_first_valid", first_err_valid, 1'b0);
        check_eq("t3_vnum", vectornum, 0);
        @(negedge clk);
        check_eq("t3_no_reads", rd_count - base_rd, 0);

        // Reset during APPLY of index 5 of 10
        for (int i = 0; i < 10; i++) begin
            vmem[i] = pk(16'h3C00, 16'h4000 + 16'(i), 16'h0000, 8'h08, 16'h4000 + 16'(i), 4'h0);
        end
        pulse_start(10);
        repeat (16) @(negedge clk);
        check_eq("t4_pre_vnum", vectornum, 5);
        check_eq("t4_pre_y", y, 16'h4004);
        check_eq("t4_pre_rd", mem_rd, 1'b0);
        reset = 1'b0;
        #1;
        check_eq("t4_rst_x", x, 0);
        check_eq("t4_rst_vnum", vectornum, 0);
        check_eq("t4_rst_addr", mem_addr, 0);
        check_eq("t4_rst_busy", busy, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        pulse_start(3);
        check_eq("t4_addr0", mem_addr, 0);
        check_eq("t4_rd", mem_rd, 1'b1);
        wait_done(1, cyc);
        check_eq("t4_latency", cyc, 10);
        check_eq("t4_vnum", vectornum, 3);
        check_eq("t4_errors", errors, 0);
        check_eq("t4_last_y", y, 16'h4002);

        // start during CHECK is ignored; start after done restarts from 0
        pulse_start(3);
        repeat (2) @(negedge clk);
        start = 1'b1; num_vectors = 1;
        @(negedge clk);
        start = 1'b0;
        check_eq("t5_addr_cont", mem_addr, 1);
        check_eq("t5_vnum_cont", vectornum, 1);
        wait_done(4, cyc);
        check_eq("t5_latency", cyc, 10);
        check_eq("t5_vnum_full", vectornum, 3);
        pulse_start(2);
        check_eq("t5_restart_addr", mem_addr, 0);
        check_eq("t5_restart_vnum", vectornum, 0);
        wait_done(1, cyc);
        check_eq("t5_restart_final", vectornum, 2);

        // Correct result, wrong flags
        vmem[0] = pk(16'h3C00, 16'h4000, 16'h0000, 8'h08, 16'h4000, 4'h0);
        flags_drv = 4'b0001;
        pulse_start(1);
        wait_done(1, cyc);
`ifdef FMA16_FLAGCHECK_EN
        check_eq("t6_errors", errors, 1);
        check_eq("t6_flag_errors", flag_errors, 1);
`else
        check_eq("t6_errors", errors, 0);
        check_eq("t6_first_valid", first_err_valid, 1'b0);
`endif
        flags_drv = 4'h0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
